// File: rtl/sparc_muldiv_unit.sv
// sparc_muldiv_unit
//   Iterative multiply/divide unit for SPARC V8 UMUL/SMUL/UDIV/SDIV and the
//   cc forms. Multiply is radix-2 shift-add (WIDTH iterations). Divide is
//   restoring, over the 2*WIDTH dividend {Y, rs1} (2*WIDTH iterations).
//   Signed ops work on magnitudes. The FIX state applies the sign, saturates
//   divide overflow and forms rd, Y and the icc flags.
//
//   Ports:
//     clk, reset             clock, synchronous active-high reset
//     in_valid / in_ready    op handshake (in_ready high only when idle)
//     op3, oprd2, oprd3      opcode, rs1 value, rs2/simm13 value
//     y_in, rflags_in        current Y and rflags
//     out_valid / out_ready  result handshake
//     result, y_out          new rd and Y
//     rflags_out             new rflags (icc bits updated for cc forms only)
//     div_zero, illegal      status, qualified by out_valid
//
//   Optional feature macro: MULDIV_EARLY_OUT_EN. When it is defined, a
//   multiply with a zero operand magnitude goes straight to FIX.
//
//   icc bit positions come from RF_N/RF_Z/RF_V/RF_C. If the macros are not
//   already defined, the SPARC PSR positions are used.

`ifndef RF_N
`define RF_N 23
`endif
`ifndef RF_Z
`define RF_Z 22
`endif
`ifndef RF_V
`define RF_V 21
`endif
`ifndef RF_C
`define RF_C 20
`endif

module sparc_muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int RFLAGS_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5:0]          op3,
  input  logic [WIDTH-1:0]    oprd2,
  input  logic [WIDTH-1:0]    oprd3,
  input  logic [WIDTH-1:0]    y_in,
  input  logic [RFLAGS_W-1:0] rflags_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic [WIDTH-1:0]    y_out,
  output logic [RFLAGS_W-1:0] rflags_out,
  output logic                div_zero,
  output logic                illegal
);

  localparam int CW = $clog2(2*WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]          state;
  logic                op_div, op_sgn, op_cc, neg;
  logic [WIDTH-1:0]    a_mag;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]  acc;     // mul: {partial hi, multiplier lo}; div: dividend/quotient
  logic [WIDTH-1:0]    rem;     // div partial remainder
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    y_l;
  logic [RFLAGS_W-1:0] rf_l;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Decode and operand magnitudes for the op being presented.
  logic               legal, is_div, is_sgn, is_cc;
  logic               s1_neg, s2_neg, dvd_neg;
  logic [WIDTH-1:0]   m1, m2;
  logic [2*WIDTH-1:0] dvd, dvd_mag;

  always_comb begin
    legal   = !op3[5] && (op3[3:0] == 4'hA || op3[3:0] == 4'hB ||
                          op3[3:0] == 4'hE || op3[3:0] == 4'hF);
    is_div  = op3[2];
    is_sgn  = op3[0];
    is_cc   = op3[4];
    s1_neg  = is_sgn && oprd2[WIDTH-1];
    s2_neg  = is_sgn && oprd3[WIDTH-1];
    m1      = s1_neg ? -oprd2 : oprd2;
    m2      = s2_neg ? -oprd3 : oprd3;
    dvd     = {y_in, oprd2};
    dvd_neg = is_sgn && y_in[WIDTH-1];
    dvd_mag = dvd_neg ? -dvd : dvd;
  end

  // One CALC iteration.
  logic [WIDTH:0]     msum, shifted, diff;
  logic               ge;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt;
  logic [WIDTH-1:0]   rem_nxt;

  always_comb begin
    msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    mul_nxt = {msum, acc[WIDTH-1:1]};
    shifted = {rem, acc[2*WIDTH-1]};
    ge      = (shifted >= {1'b0, a_mag});
    diff    = shifted - {1'b0, a_mag};
    rem_nxt = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    div_nxt = {acc[2*WIDTH-2:0], ge};
  end

  // FIX: sign correction, saturation and flags.
  logic [2*WIDTH-1:0]  prod;
  logic                ovf;
  logic [WIDTH-1:0]    qres, fix_res, fix_y;
  logic [RFLAGS_W-1:0] fix_rf;

  always_comb begin
    prod = neg ? -acc : acc;
    if (!op_sgn)
      ovf = |acc[2*WIDTH-1:WIDTH];
    else if (!neg)
      ovf = |acc[2*WIDTH-1:WIDTH-1];          // magnitude above 2^(W-1)-1
    else
      ovf = |acc[2*WIDTH-1:WIDTH] ||
            (acc[WIDTH-1] && |acc[WIDTH-2:0]); // magnitude above 2^(W-1)
    if (!op_sgn)
      qres = ovf ? '1 : acc[WIDTH-1:0];
    else if (!neg)
      qres = ovf ? {1'b0, {(WIDTH-1){1'b1}}} : acc[WIDTH-1:0];
    else
      qres = ovf ? {1'b1, {(WIDTH-1){1'b0}}} : -acc[WIDTH-1:0];
    fix_res = op_div ? qres : prod[WIDTH-1:0];
    fix_y   = op_div ? y_l  : prod[2*WIDTH-1:WIDTH];
    fix_rf  = rf_l;
    if (op_cc) begin
      fix_rf[`RF_N] = fix_res[WIDTH-1];
      fix_rf[`RF_Z] = (fix_res == '0);
      fix_rf[`RF_V] = op_div && ovf;
      fix_rf[`RF_C] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_div     <= 1'b0;
      op_sgn     <= 1'b0;
      op_cc      <= 1'b0;
      neg        <= 1'b0;
      a_mag      <= '0;
      acc        <= '0;
      rem        <= '0;
      cnt        <= '0;
      y_l        <= '0;
      rf_l       <= '0;
      result     <= '0;
      y_out      <= '0;
      rflags_out <= '0;
      div_zero   <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_div   <= is_div;
          op_sgn   <= is_sgn;
          op_cc    <= is_cc;
          y_l      <= y_in;
          rf_l     <= rflags_in;
          rem      <= '0;
          div_zero <= 1'b0;
          illegal  <= 1'b0;
          if (!legal || (is_div && oprd3 == '0)) begin
            // No computation: outputs are final at accept.
            result     <= '0;
            y_out      <= y_in;
            rflags_out <= rflags_in;
            illegal    <= !legal;
            div_zero   <= legal;
            state      <= S_DONE;
          end else if (is_div) begin
            neg   <= dvd_neg ^ s2_neg;
            acc   <= dvd_mag;
            a_mag <= m2;
            cnt   <= CW'(2*WIDTH-1);
            state <= S_CALC;
          end else begin
            neg   <= s1_neg ^ s2_neg;
            a_mag <= m1;
            cnt   <= CW'(WIDTH-1);
`ifdef MULDIV_EARLY_OUT_EN
            if (m1 == '0 || m2 == '0) begin
              acc   <= '0;
              state <= S_FIX;
            end else begin
              acc   <= {{WIDTH{1'b0}}, m2};
              state <= S_CALC;
            end
`else
            acc   <= {{WIDTH{1'b0}}, m2};
            state <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          if (op_div) begin
            acc <= div_nxt;
            rem <= rem_nxt;
          end else begin
            acc <= mul_nxt;
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= S_FIX;
        end
        S_FIX: begin
          result     <= fix_res;
          y_out      <= fix_y;
          rflags_out <= fix_rf;
          state      <= S_DONE;
        end
        default: if (out_ready) state <= S_IDLE;
      endcase
    end
  end

endmodule
